hls_deadlock_persist_monitor: RTL
=================================

# hls_deadlock_persist_monitor

Parametrised deadlock monitor for one HLS instance hierarchy level: reduces N AXI-stream block flags and M sub-instance block/idle flag pairs into a registered `block` indication that only asserts once a stall has persisted for a programmable number of cycles. It also latches a sticky flag and the index of the first blocking source for post-mortem readout, and reports a saturating stall-length counter. It sits beside each generated top-level instance and feeds the parent monitor's `inst_block_sigs`.

## Interface
- `N_AXIS`, 4, number of AXI-stream block inputs (≥1)
- `N_INST`, 1, number of sub-instance block/idle pairs (≥0; 0 removes those ports' effect)
- `THRESHOLD`, 1, consecutive raw-block cycles required before `block` asserts (≥1)
- `CNT_W`, 16, width of stall-length counter
- `SRC_W`, $clog2(N_AXIS+N_INST) (min 1), width of source index (derived, not overridden)

- `clock` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `axis_block_sigs` in N_AXIS — per-stream blocked flag
- `inst_idle_sigs` in max(N_INST,1) — per sub-instance idle
- `inst_block_sigs` in max(N_INST,1) — per sub-instance blocked
- `clear` in 1 — clears sticky flag and captured source
- `block` out 1 — persistent stall detected (registered)
- `block_sticky` out 1 — a stall has been detected since last reset/clear
- `first_src_idx` out SRC_W — source that triggered the first detected stall
- `stall_cnt` out CNT_W — length of current stall episode, saturating

## Operation
- Per-source raw flag: axis source i = `axis_block_sigs[i]`; instance source j (index N_AXIS+j) = `inst_block_sigs[j] & ~inst_idle_sigs[j]` (idle instance never counts as blocked).
- `raw` = OR of all source flags.
- FSM states IDLE, ARMED, BLOCKED; reset → IDLE.
  - IDLE: raw=0 stay. raw=1 → BLOCKED if THRESHOLD=1, else → ARMED with persist count=1.
  - ARMED: raw=0 → IDLE, count=0. raw=1 and count=THRESHOLD-1 → BLOCKED. Else count+1.
  - BLOCKED: raw=1 stay; raw=0 → IDLE.
- `block` = registered (state==BLOCKED).
- `stall_cnt`: 0 while raw=0 (next cycle); increments by 1 each cycle raw=1, starting at 1 on first raw cycle; saturates at 2^CNT_W-1, no wrap.
- Sticky/capture: on any transition into BLOCKED while `block_sticky`=0, set `block_sticky` and load `first_src_idx` with lowest-index active source in that same cycle. Later stalls do not overwrite until cleared.
- `clear`=1: `block_sticky`←0, `first_src_idx`←0. If clear coincides with a transition into BLOCKED, set/capture wins. `clear` does not affect FSM, `block`, `stall_cnt`.
- Reset mid-stall: all state and outputs to 0/IDLE; count restarts from 0 even if raw stays high.

## Timing
- Reset values: `block`=0, `block_sticky`=0, `first_src_idx`=0, `stall_cnt`=0, state IDLE.
- Raw high from cycle k through k+THRESHOLD-1 → `block` high from cycle k+THRESHOLD. THRESHOLD=1 gives one-cycle latency.
- Raw drops in cycle m → `block` low in cycle m+1.
- `block_sticky` and `first_src_idx` update on the same edge as `block` rising.
- `stall_cnt` = number of consecutive raw cycles up to and including the previous cycle.
- Any single-cycle raw gap in ARMED restarts the persistence count.
- No combinational input-to-output paths.

## Structure
- Shared package `hls_deadlock_pkg`: FSM state enum (IDLE/ARMED/BLOCKED), function `src_w(n)` returning max(1,$clog2(n)).
- Sub-module `hls_deadlock_src_encoder`: combinational lowest-index priority encoder over N_AXIS+N_INST source flags, outputs index and valid.

## Test plan
- THRESHOLD=1, N_AXIS=4, N_INST=0: pulse `axis_block_sigs`=4'b0100 for 1 cycle → `block` high exactly 1 cycle, next cycle; `first_src_idx`=2, `block_sticky`=1.
- THRESHOLD=4: raw high 3 cycles, low 1, high 4 → no `block` on first burst; `block` rises cycle 4 of second burst +1; `stall_cnt` reaches 4.
- N_INST=2: `inst_block_sigs`=2'b10, `inst_idle_sigs`=2'b10 → no block; deassert idle → block, `first_src_idx`=5.
- Second stall from axis 0 after first from axis 3 → `first_src_idx` stays 3; assert `clear` → idx 0, sticky 0; third stall from axis 0 → idx 0.
- CNT_W=3, raw high 12 cycles → `stall_cnt` saturates at 7; raw low → 0 next cycle.
- Reset asserted during BLOCKED with raw held high, THRESHOLD=4 → all outputs 0 next cycle; `block` re-asserts 4 cycles after reset release.

Source files
------------

// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS deadlock persistence monitor.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_BLOCKED
  } state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int src_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/hls_deadlock_src_encoder.sv
// Lowest-index priority encoder over the per-source block flags.
module hls_deadlock_src_encoder #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_SRC-1:0] src_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (src_i[i] && !valid_o) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor: asserts block once any source has stalled for THRESHOLD
// consecutive cycles, with sticky first-source capture and a stall counter.
module hls_deadlock_persist_monitor
  import hls_deadlock_pkg::*;
#(
  parameter int N_AXIS    = 4,
  parameter int N_INST    = 1,
  parameter int THRESHOLD = 1,
  parameter int CNT_W     = 16,
  localparam int SRC_W    = src_w(N_AXIS + N_INST),
  localparam int INST_W   = (N_INST > 0) ? N_INST : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [INST_W-1:0] inst_idle_sigs,
  input  logic [INST_W-1:0] inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic              block_sticky,
  output logic [SRC_W-1:0]  first_src_idx,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int N_SRC = N_AXIS + N_INST;
  localparam int PC_W  = src_w(THRESHOLD);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(THRESHOLD - 1);

  logic [N_SRC-1:0] src;
  logic [SRC_W-1:0] enc_idx;
  logic             raw;
  logic             enter_blk;

  state_e           state_q;
  logic [PC_W-1:0]  persist_q;
  logic             block_q;
  logic             sticky_q;
  logic [SRC_W-1:0] idx_q;
  logic [CNT_W-1:0] stall_q;

  // An idle sub-instance never counts as blocked.
  if (N_INST > 0) begin : g_inst
    assign src = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};
  end else begin : g_no_inst
    logic unused_inst;
    assign src         = axis_block_sigs;
    assign unused_inst = ^{inst_idle_sigs, inst_block_sigs};
  end

  hls_deadlock_src_encoder #(
    .N_SRC (N_SRC),
    .IDX_W (SRC_W)
  ) u_enc (
    .src_i   (src),
    .idx_o   (enc_idx),
    .valid_o (raw)
  );

  always_comb begin
    enter_blk = 1'b0;
    if (raw) begin
      case (state_q)
        ST_IDLE:  enter_blk = (THRESHOLD == 1);
        ST_ARMED: enter_blk = (persist_q == PC_LAST);
        default:  enter_blk = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      persist_q <= '0;
      block_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enter_blk) begin
            state_q <= ST_BLOCKED;
            block_q <= 1'b1;
          end else if (raw) begin
            state_q   <= ST_ARMED;
            persist_q <= PC_W'(1);
          end
        end
        ST_ARMED: begin
          if (!raw) begin
            state_q   <= ST_IDLE;
            persist_q <= '0;
          end else if (enter_blk) begin
            state_q   <= ST_BLOCKED;
            persist_q <= '0;
            block_q   <= 1'b1;
          end else begin
            persist_q <= persist_q + PC_W'(1);
          end
        end
        ST_BLOCKED: begin
          if (!raw) begin
            state_q <= ST_IDLE;
            block_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          persist_q <= '0;
          block_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !raw) begin
      stall_q <= '0;
    end else if (stall_q != '1) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // A capture on entry to BLOCKED takes priority over a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_q <= 1'b0;
      idx_q    <= '0;
    end else if (enter_blk && (!sticky_q || clear)) begin
      sticky_q <= 1'b1;
      idx_q    <= enc_idx;
    end else if (clear) begin
      sticky_q <= 1'b0;
      idx_q    <= '0;
    end
  end

  assign block         = block_q;
  assign block_sticky  = sticky_q;
  assign first_src_idx = idx_q;
  assign stall_cnt     = stall_q;

endmodule
